// File: rtl/dmem_bus_master_if.sv
// rtl/dmem_bus_master_if.sv - Wishbone-classic data bus between the load/store master and the interconnect
interface dmem_bus_master_if #(
    parameter int ADDR_W = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat_w;
    logic [3:0]        sel;
    logic [31:0]       dat_r;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err
    );
endinterface

// File: rtl/dmem_bus_master.sv
// rtl/dmem_bus_master.sv - mem-stage load/store to single-outstanding Wishbone-classic transaction
module dmem_bus_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_m_en_access,
    input  logic                 i_m_we,
    input  logic [2:0]           i_m_funct3,
    input  logic [ADDR_W-1:0]    i_m_addr,
    input  logic [31:0]          i_m_wdata,
    output logic [31:0]          o_m_rdata,
    output logic                 o_m_ack,
    output logic                 o_m_err,
    dmem_bus_master_if.master    bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       dat_q, dat_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic        funct3_ok;
    logic        misaligned;
    logic [3:0]  sel_new;
    logic [31:0] dat_new;
    logic [31:0] load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Lane steering for the incoming access; byte/half/word taken from funct3[1:0].
    always_comb begin
        sel_new    = 4'b0000;
        dat_new    = i_m_wdata;
        funct3_ok  = 1'b0;
        misaligned = 1'b0;
        case (i_m_funct3[1:0])
            2'b00: begin
                sel_new   = 4'b0001 << i_m_addr[1:0];
                dat_new   = {4{i_m_wdata[7:0]}};
                funct3_ok = 1'b1;
            end
            2'b01: begin
                sel_new    = i_m_addr[1] ? 4'b1100 : 4'b0011;
                dat_new    = {2{i_m_wdata[15:0]}};
                funct3_ok  = 1'b1;
                misaligned = i_m_addr[0];
            end
            2'b10: begin
                sel_new    = 4'b1111;
                dat_new    = i_m_wdata;
                funct3_ok  = !i_m_funct3[2];
                misaligned = (i_m_addr[1:0] != 2'b00);
            end
            default: begin
                funct3_ok = 1'b0;
            end
        endcase
        if (!funct3_ok) begin
            misaligned = 1'b1;
        end
    end

    // Load extraction uses the registered offset/funct3 so mem-stage changes cannot corrupt it.
    always_comb begin
        ld_byte   = 8'h00;
        ld_half   = 16'h0000;
        load_data = 32'h0000_0000;
        case (off_q)
            2'd0:    ld_byte = bus.dat_r[7:0];
            2'd1:    ld_byte = bus.dat_r[15:8];
            2'd2:    ld_byte = bus.dat_r[23:16];
            default: ld_byte = bus.dat_r[31:24];
        endcase
        ld_half = off_q[1] ? bus.dat_r[31:16] : bus.dat_r[15:0];
        case (f3_q[1:0])
            2'b00:   load_data = {{24{ld_byte[7] & !f3_q[2]}}, ld_byte};
            2'b01:   load_data = {{16{ld_half[15] & !f3_q[2]}}, ld_half};
            default: load_data = bus.dat_r;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_m_en_access) begin
                    if (misaligned) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0000_0000;
                    end else begin
                        state_d = REQ;
                        adr_d   = {i_m_addr[ADDR_W-1:2], 2'b00};
                        we_d    = i_m_we;
                        sel_d   = sel_new;
                        dat_d   = dat_new;
                        f3_d    = i_m_funct3;
                        off_d   = i_m_addr[1:0];
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.err) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'h0000_0000;
                end else if (bus.ack) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'h0000_0000 : load_data;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_MAX)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'h0000_0000;
                end
            end
            RESP: begin
                // The same instruction still holds en_access here; only IDLE may launch.
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
                rdata_d = 32'h0000_0000;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= 4'b0000;
            dat_q   <= 32'h0000_0000;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.cyc   = (state_q == REQ);
    assign bus.stb   = (state_q == REQ);
    assign bus.we    = we_q;
    assign bus.adr   = adr_q;
    assign bus.dat_w = dat_q;
    assign bus.sel   = sel_q;

    assign o_m_ack   = (state_q == RESP);
    assign o_m_err   = err_q;
    assign o_m_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_bus_master.sv
// tb/tb_dmem_bus_master.sv - directed self-checking bench for dmem_bus_master
module tb_dmem_bus_master;

    logic        clk;
    logic        rst;
    logic        en_a;
    logic        en_b;
    logic        m_we;
    logic [2:0]  m_f3;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, ack_b;
    logic        err_a, err_b;

    int checks = 0;
    int errors = 0;

    dmem_bus_master_if #(.ADDR_W(32)) bus_a ();
    dmem_bus_master_if #(.ADDR_W(32)) bus_b ();

    dmem_bus_master #(.ADDR_W(32), .TIMEOUT(255)) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_m_en_access (en_a),
        .i_m_we        (m_we),
        .i_m_funct3    (m_f3),
        .i_m_addr      (m_addr),
        .i_m_wdata     (m_wdata),
        .o_m_rdata     (rdata_a),
        .o_m_ack       (ack_a),
        .o_m_err       (err_a),
        .bus           (bus_a.master)
    );

    dmem_bus_master #(.ADDR_W(32), .TIMEOUT(4)) u_dut_to (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_m_en_access (en_b),
        .i_m_we        (m_we),
        .i_m_funct3    (m_f3),
        .i_m_addr      (m_addr),
        .i_m_wdata     (m_wdata),
        .o_m_rdata     (rdata_b),
        .o_m_ack       (ack_b),
        .o_m_err       (err_b),
        .bus           (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Aligned access with `waits` wait states before the slave acks; leaves en_a high into IDLE.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdat, input int waits,
                          input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                          input logic [31:0] exp_rdata);
        en_a    = 1'b1;
        m_we    = we;
        m_f3    = f3;
        m_addr  = addr;
        m_wdata = wdata;
        tick();
        for (int i = 0; i <= waits; i++) begin
            chk({tag, " stb"}, {31'd0, bus_a.stb}, 32'd1);
            chk({tag, " cyc"}, {31'd0, bus_a.cyc}, 32'd1);
            chk({tag, " sel"}, {28'd0, bus_a.sel}, {28'd0, exp_sel});
            chk({tag, " adr"}, bus_a.adr, {addr[31:2], 2'b00});
            chk({tag, " we"}, {31'd0, bus_a.we}, {31'd0, we});
            if (we) chk({tag, " dat"}, bus_a.dat_w, exp_dat);
            chk({tag, " m_ack low"}, {31'd0, ack_a}, 32'd0);
            if (i == waits) begin
                bus_a.ack   = 1'b1;
                bus_a.dat_r = rdat;
            end
            tick();
        end
        bus_a.ack   = 1'b0;
        bus_a.dat_r = 32'h0;
        chk({tag, " m_ack"}, {31'd0, ack_a}, 32'd1);
        chk({tag, " m_err"}, {31'd0, err_a}, 32'd0);
        chk({tag, " rdata"}, rdata_a, exp_rdata);
        chk({tag, " cyc drop"}, {31'd0, bus_a.cyc}, 32'd0);
        tick();
        chk({tag, " ack pulse"}, {31'd0, ack_a}, 32'd0);
        chk({tag, " no relaunch"}, {31'd0, bus_a.cyc}, 32'd0);
    endtask

    task automatic bad_access(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        en_a   = 1'b1;
        m_we   = 1'b0;
        m_f3   = f3;
        m_addr = addr;
        tick();
        chk({tag, " m_ack"}, {31'd0, ack_a}, 32'd1);
        chk({tag, " m_err"}, {31'd0, err_a}, 32'd1);
        chk({tag, " rdata"}, rdata_a, 32'h0);
        chk({tag, " cyc"}, {31'd0, bus_a.cyc}, 32'd0);
        tick();
        chk({tag, " ack pulse"}, {31'd0, ack_a}, 32'd0);
        chk({tag, " cyc after"}, {31'd0, bus_a.cyc}, 32'd0);
        en_a = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b0; en_b = 1'b0;
        m_we = 1'b0; m_f3 = 3'b010; m_addr = 32'h0; m_wdata = 32'h0;
        bus_a.dat_r = 32'h0; bus_a.ack = 1'b0; bus_a.err = 1'b0;
        bus_b.dat_r = 32'h0; bus_b.ack = 1'b0; bus_b.err = 1'b0;
        tick();
        tick();
        chk("reset cyc", {31'd0, bus_a.cyc}, 32'd0);
        chk("reset stb", {31'd0, bus_a.stb}, 32'd0);
        chk("reset we", {31'd0, bus_a.we}, 32'd0);
        chk("reset adr", bus_a.adr, 32'h0);
        chk("reset dat", bus_a.dat_w, 32'h0);
        chk("reset sel", {28'd0, bus_a.sel}, 32'd0);
        chk("reset rdata", rdata_a, 32'h0);
        chk("reset ack", {31'd0, ack_a}, 32'd0);
        chk("reset err", {31'd0, err_a}, 32'd0);
        rst = 1'b0;
        tick();

        access("lw wait3", 1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 3,
               4'b1111, 32'h0, 32'hDEAD_BEEF);
        // Back-to-back: each access starts in the IDLE cycle right after the previous RESP.
        access("lb", 1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h80FF_0000, 0,
               4'b1000, 32'h0, 32'hFFFF_FF80);
        access("lbu", 1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h80FF_0000, 0,
               4'b1000, 32'h0, 32'h0000_0080);
        access("lhu", 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h80FF_0000, 0,
               4'b1100, 32'h0, 32'h0000_80FF);
        access("lh", 1'b0, 3'b001, 32'h0000_2000, 32'h0, 32'h1234_8001, 1,
               4'b0011, 32'h0, 32'hFFFF_8001);
        access("sh", 1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 32'h0, 0,
               4'b1100, 32'hABCD_ABCD, 32'h0);
        access("sb", 1'b1, 3'b000, 32'h0000_3001, 32'h0000_005A, 32'h0, 0,
               4'b0010, 32'h5A5A_5A5A, 32'h0);
        en_a = 1'b0;
        tick();

        bad_access("lw misalign", 3'b010, 32'h0000_4001);
        bad_access("lh misalign", 3'b001, 32'h0000_4003);
        bad_access("funct3 011", 3'b011, 32'h0000_4000);

        // Slave never answers: TIMEOUT=4 instance holds stb four cycles then errors.
        en_b = 1'b1; m_we = 1'b0; m_f3 = 3'b010; m_addr = 32'h0000_5000;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("timeout stb", {31'd0, bus_b.stb}, 32'd1);
            chk("timeout no ack", {31'd0, ack_b}, 32'd0);
            tick();
        end
        chk("timeout m_ack", {31'd0, ack_b}, 32'd1);
        chk("timeout m_err", {31'd0, err_b}, 32'd1);
        chk("timeout stb drop", {31'd0, bus_b.stb}, 32'd0);
        chk("timeout rdata", rdata_b, 32'h0);
        en_b = 1'b0;
        tick();
        chk("timeout ack pulse", {31'd0, ack_b}, 32'd0);

        // ack and err together: err wins.
        en_a = 1'b1; m_we = 1'b0; m_f3 = 3'b010; m_addr = 32'h0000_5100;
        tick();
        chk("ackerr stb", {31'd0, bus_a.stb}, 32'd1);
        bus_a.ack = 1'b1; bus_a.err = 1'b1; bus_a.dat_r = 32'h1111_2222;
        tick();
        bus_a.ack = 1'b0; bus_a.err = 1'b0;
        chk("ackerr m_ack", {31'd0, ack_a}, 32'd1);
        chk("ackerr m_err", {31'd0, err_a}, 32'd1);
        chk("ackerr rdata", rdata_a, 32'h0);
        en_a = 1'b0;
        tick();

        // Reset during the second REQ cycle, with a late slave ack afterwards.
        en_a = 1'b1; m_we = 1'b0; m_f3 = 3'b010; m_addr = 32'h0000_6000;
        tick();
        chk("rst req1 stb", {31'd0, bus_a.stb}, 32'd1);
        tick();
        chk("rst req2 stb", {31'd0, bus_a.stb}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en_a = 1'b0;
        bus_a.ack = 1'b1; bus_a.dat_r = 32'hCAFE_F00D;
        chk("rst cyc drop", {31'd0, bus_a.cyc}, 32'd0);
        chk("rst no ack", {31'd0, ack_a}, 32'd0);
        tick();
        bus_a.ack = 1'b0;
        chk("rst late ack ignored", {31'd0, ack_a}, 32'd0);
        chk("rst idle cyc", {31'd0, bus_a.cyc}, 32'd0);

        access("sw after rst", 1'b1, 3'b010, 32'h0000_7004, 32'h1234_5678, 32'h0, 0,
               4'b1111, 32'h1234_5678, 32'h0);
        en_a = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bus_master.md
Name: dmem_bus_master

Overview:
- Memory-stage load/store bus master. It converts the mem-stage data access (address, store data, funct3) into a single-outstanding Wishbone-classic transaction.
- It returns aligned, sign- or zero-extended load data and a one-cycle completion pulse. The hazard unit consumes that pulse as its bus-ack input, which releases the pipeline stall.
- Sits between the pipeline mem stage and the data bus interconnect.

Parameters:
- ADDR_W, 32, bus address width.
- TIMEOUT, 255, cycles to wait for bus ack/err before forcing completion with error; 0 disables the timeout.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_m_en_access  in  1  mem stage holds a load/store; held high for the whole stall
- i_m_we  in  1  1 = store, 0 = load
- i_m_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- i_m_addr  in  ADDR_W  byte address from ALU
- i_m_wdata  in  32  store data, right-aligned
- o_m_rdata  out  32  extended load data; valid while o_m_ack=1
- o_m_ack  out  1  one-cycle completion pulse to the hazard unit
- o_m_err  out  1  completion with error (misaligned, bus err, timeout); only meaningful with o_m_ack
- o_bus_cyc  out  1  Wishbone cycle
- o_bus_stb  out  1  Wishbone strobe
- o_bus_we  out  1  Wishbone write enable
- o_bus_adr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- o_bus_dat  out  32  write data, lane-replicated
- o_bus_sel  out  4  byte lane select
- i_bus_dat  in  32  read data
- i_bus_ack  in  1  transfer done
- i_bus_err  in  1  transfer error

Behaviour:
- Reset:
  - i_rst sampled high forces state IDLE on the next edge.
  - All outputs 0: cyc, stb, we, adr, dat, sel, rdata, ack, err.
  - The timeout counter clears to 0.
  - Reset mid-transaction drops cyc/stb on the next cycle. No ack is issued, and any late bus ack is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE, on i_m_en_access=1:
  - Misalignment check: misaligned if halfword with addr[0]=1, or word with addr[1:0]!=0.
  - If misaligned: go to RESP with err=1 and rdata=0. No bus cycle is issued.
  - Otherwise: register adr, we, sel, dat, funct3 and addr[1:0], then go to REQ.
- REQ:
  - cyc=stb=1. Registered request fields are held stable regardless of mem-stage inputs.
  - On i_bus_ack: capture extracted rdata (loads; 0 for stores), go to RESP with err=0.
  - On i_bus_err: go to RESP with err=1 and rdata=0. err takes priority if ack and err arrive together.
  - The counter increments each REQ cycle. When it reaches TIMEOUT-1 with no ack/err: go to RESP with err=1.
  - cyc/stb deassert on the cycle after ack, err or timeout.
- RESP:
  - o_m_ack=1 and o_m_err valid for exactly one cycle, then IDLE.
  - i_m_en_access is still high in RESP (same instruction); it must not start a new request.
- Back-to-back accesses: the new instruction arrives the cycle after RESP and is accepted in IDLE with no bubble.
- Latency: access seen at cycle T; stb at T+1; zero-wait ack at T+1 gives o_m_ack at T+2. Misaligned: o_m_ack at T+1.
- Store lane rules:
  - SB: sel = 1<<addr[1:0], dat = {4{wdata[7:0]}}.
  - SH: sel = addr[1] ? 1100 : 0011, dat = {2{wdata[15:0]}}.
  - SW: sel = 1111.
- Load lane rules: sel as for stores. The byte/half is selected by the registered addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Invalid funct3 (011, 11x) is treated as misaligned (error completion).

Test Plan:
- LW at 0x1000, bus acks 0xDEADBEEF after 3 wait cycles -> stb high 4 cycles with sel=1111, adr=0x1000; o_m_ack one cycle later with o_m_rdata=0xDEADBEEF, err=0.
- LB addr 0x2003, bus data 0x80FF0000 -> sel=1000, rdata=0xFFFFFF80. LBU same access -> rdata=0x00000080. LHU addr 0x2002 -> sel=1100, rdata=0x000080FF.
- SH addr 0x3002, wdata 0x0000ABCD, zero-wait ack -> we=1, sel=1100, dat=0xABCDABCD; o_m_ack at T+2.
- LW addr 0x4001 -> no cyc/stb ever; o_m_ack=1 and o_m_err=1 at T+1, rdata=0.
- TIMEOUT=4, bus never answers -> stb high 4 cycles, then o_m_ack with o_m_err=1. Separately, ack and err in the same cycle -> err=1.
- i_rst pulsed during REQ (cycle 2 of wait), bus acks next cycle -> cyc=0 the cycle after reset, o_m_ack stays 0, FSM in IDLE. A following SW completes normally.
